// File: rtl/pixel_stream_profiler.sv
// pixel_stream_profiler
//   Profiles a pixel stream at the byte-to-pixel output. It measures line
//   length, lines per frame and a 32-bit per-frame data signature, and it
//   flags lines or frames whose size differs from the programmed expectation.
//   Framing comes from DSI (de_o/vsync) or CSI-2 (line_valid/frame_valid),
//   and the stream carries 1, 2 or 4 pixels per clock.
//
// Ports
//   clk          pixel clock
//   reset        asynchronous, active-low reset
//   de_o, vsync  DSI data enable / vertical sync (used when RX_TYPE="DSI")
//   line_valid,
//   frame_valid  CSI-2 framing (used when RX_TYPE="CSI2")
//   pixel_data   PIXEL_COUNT lanes of PIXEL_WIDTH bits; lane k at [k*W +: W]
//   err_clear    clears the sticky error flags
//   line_len     pixel count of the last completed line
//   frame_lines  line count of the last completed frame
//   frame_sig    signature of the last completed frame
//   frame_done   one-cycle pulse when a frame closes
//   frame_cnt    completed frames since reset (saturating)
//   err_line_len sticky: a line length differed from EXP_PIXELS
//   err_line_cnt sticky: a frame line count differed from EXP_LINES
module pixel_stream_profiler #(
    parameter string RX_TYPE     = "DSI",
    parameter int    PIXEL_WIDTH = 24,
    parameter int    PIXEL_COUNT = 1,
    parameter int    EXP_PIXELS  = 1920,
    parameter int    EXP_LINES   = 1080,
    parameter int    CNT_W       = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               de_o,
    input  logic                               vsync,
    input  logic                               line_valid,
    input  logic                               frame_valid,
    input  logic [PIXEL_WIDTH*PIXEL_COUNT-1:0] pixel_data,
    input  logic                               err_clear,
    output logic [CNT_W-1:0]                   line_len,
    output logic [CNT_W-1:0]                   frame_lines,
    output logic [31:0]                        frame_sig,
    output logic                               frame_done,
    output logic [CNT_W-1:0]                   frame_cnt,
    output logic                               err_line_len,
    output logic                               err_line_cnt
);

    localparam bit               IS_CSI2   = (RX_TYPE == "CSI2");
    localparam bit               CHK_PIX   = (EXP_PIXELS != 0);
    localparam bit               CHK_LINES = (EXP_LINES != 0);
    localparam int               DW        = PIXEL_WIDTH * PIXEL_COUNT;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] EXP_PIX_C = CNT_W'(EXP_PIXELS);
    localparam logic [CNT_W-1:0] EXP_LIN_C = CNT_W'(EXP_LINES);
    localparam logic [CNT_W:0]   PIX_STEP  = (CNT_W+1)'(PIXEL_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FRAME,
        ST_LINE
    } state_t;

    state_t state_q, state_d;

    // Input stage (s1) and previous-sample history (p1)
    logic          de_s1, vs_s1, lv_s1, fv_s1;
    logic [DW-1:0] pd_s1;
    logic          s1_valid;
    logic          vs_p1, fv_p1;

    logic             armed, armed_d;
    logic [CNT_W-1:0] pix_cnt, pix_cnt_d;
    logic [CNT_W-1:0] line_cnt, line_cnt_d;
    logic [31:0]      sig, sig_d;

    logic             f_ind, a_ind, f_rise, f_fall;
    logic             frame_start, frame_end, cnt_en, line_close;
    logic [CNT_W-1:0] closed_lines;
    logic [CNT_W:0]   pix_sum;
    logic [31:0]      fold, sig_base;
    logic             el_set, ec_set;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    always_comb begin
        fold = '0;
        for (int unsigned k = 0; k < PIXEL_COUNT; k++) begin
            fold = fold ^ 32'(pd_s1[k*PIXEL_WIDTH +: PIXEL_WIDTH]);
        end
    end

    always_comb begin
        f_ind        = IS_CSI2 ? fv_s1 : (vs_s1 & ~vs_p1);
        a_ind        = IS_CSI2 ? (lv_s1 & fv_s1) : de_s1;
        // DSI frame indicator is already a pulse, so its "rise" is itself
        f_rise       = IS_CSI2 ? (fv_s1 & ~fv_p1) : f_ind;
        f_fall       = IS_CSI2 ? (~fv_s1 & fv_p1) : f_ind;

        frame_start  = armed & f_rise & (!IS_CSI2 || state_q == ST_IDLE);
        frame_end    = (state_q != ST_IDLE) & f_fall;
        // The start cycle already belongs to the new frame
        cnt_en       = a_ind & ((state_q != ST_IDLE) | frame_start);
        line_close   = (state_q == ST_LINE) & ~a_ind;

        // A line closing together with the frame is counted into it
        closed_lines = line_close ? sat_inc(line_cnt) : line_cnt;

        armed_d      = armed | (IS_CSI2 ? (s1_valid & ~fv_s1) : 1'b1);

        pix_sum      = {1'b0, pix_cnt} + PIX_STEP;
        if (frame_start) begin
            pix_cnt_d = cnt_en ? PIX_STEP[CNT_W-1:0] : '0;
        end else if (line_close) begin
            pix_cnt_d = '0;
        end else if (cnt_en) begin
            pix_cnt_d = pix_sum[CNT_W] ? CNT_MAX : pix_sum[CNT_W-1:0];
        end else begin
            pix_cnt_d = pix_cnt;
        end

        line_cnt_d   = frame_start ? '0 : closed_lines;

        sig_base     = frame_start ? '0 : sig;
        sig_d        = cnt_en ? ({sig_base[30:0], sig_base[31]} ^ fold) : sig_base;

        el_set       = line_close & CHK_PIX & (pix_cnt != EXP_PIX_C);
        ec_set       = frame_end & CHK_LINES & (closed_lines != EXP_LIN_C);
    end

    always_comb begin
        state_d = state_q;
        if (frame_start) begin
            state_d = cnt_en ? ST_LINE : ST_FRAME;
        end else if (frame_end) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_FRAME: if (a_ind)  state_d = ST_LINE;
                ST_LINE:  if (!a_ind) state_d = ST_FRAME;
                default:  state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            de_s1        <= 1'b0;
            vs_s1        <= 1'b0;
            lv_s1        <= 1'b0;
            fv_s1        <= 1'b0;
            pd_s1        <= '0;
            s1_valid     <= 1'b0;
            vs_p1        <= 1'b0;
            fv_p1        <= 1'b0;
            armed        <= 1'b0;
            pix_cnt      <= '0;
            line_cnt     <= '0;
            sig          <= '0;
            line_len     <= '0;
            frame_lines  <= '0;
            frame_sig    <= '0;
            frame_done   <= 1'b0;
            frame_cnt    <= '0;
            err_line_len <= 1'b0;
            err_line_cnt <= 1'b0;
        end else begin
            de_s1        <= de_o;
            vs_s1        <= vsync;
            lv_s1        <= line_valid;
            fv_s1        <= frame_valid;
            pd_s1        <= pixel_data;
            s1_valid     <= 1'b1;
            vs_p1        <= vs_s1;
            fv_p1        <= fv_s1;
            armed        <= armed_d;
            pix_cnt      <= pix_cnt_d;
            line_cnt     <= line_cnt_d;
            sig          <= sig_d;
            frame_done   <= frame_end;
            err_line_len <= el_set | (err_line_len & ~err_clear);
            err_line_cnt <= ec_set | (err_line_cnt & ~err_clear);
            if (line_close) line_len <= pix_cnt;
            if (frame_end) begin
                frame_lines <= closed_lines;
                frame_sig   <= sig;
                frame_cnt   <= sat_inc(frame_cnt);
            end
        end
    end

endmodule
